// File: rtl/data_bus_if_pkg.sv
// data_bus_if_pkg: constants and types shared by the MEM-stage data bus bridge.
//   state_t               - bridge FSM states (2-bit encoding)
//   REG_W                 - data/address register width
//   STALL_MEM_BIT_DEFAULT - MEM-stage index in the {wb,mem,ex,id,if,pc} stall vector
//   ZERO_WORD             - all-zero data word
//   CHIP_ENABLE/WRITE_ENABLE - active levels of the MEM request strobes
package data_bus_if_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    BUSY         = 2'b01,
    WAIT_RELEASE = 2'b10
  } state_t;

  localparam int REG_W                 = 32;
  localparam int STALL_MEM_BIT_DEFAULT = 4;

  localparam logic [REG_W-1:0] ZERO_WORD    = '0;
  localparam logic             CHIP_ENABLE  = 1'b1;
  localparam logic             WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/data_bus_if_timeout_cnt.sv
// bus_timeout_cnt: counts BUSY cycles without acknowledge and flags expiry.
//   clk, rst - clock, synchronous active-high reset
//   clear    - force the count back to zero (used whenever no transaction is open)
//   enable   - count this cycle (transaction outstanding)
//   expire   - count has reached TIMEOUT_CYCLES-1 while enabled
// The count saturates at TIMEOUT_CYCLES-1, so it can never wrap past the limit.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_bus_if.sv
// data_bus_if: bridges the MEM stage's single-cycle data-memory request onto a
// multi-cycle ack-handshake bus, stalling the pipeline while the access is open.
//   clk, rst               - clock, synchronous active-high reset
//   cpu_ce_i/we_i/sel_i    - MEM request valid, write flag, byte lanes
//   cpu_addr_i/data_i      - MEM byte address and lane-replicated write data
//   cpu_data_o             - read data back to MEM (held while MEM is stalled)
//   stallreq_o             - stall request to the pipeline controller
//   stall_i, flush_i       - controller stall vector and pipeline flush
//   err_o                  - one-cycle pulse when a transaction times out
//   bus_cyc/stb/we/sel/addr/data_o - registered bus request
//   bus_data_i, bus_ack_i  - bus read data and acknowledge
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int STALL_MEM_BIT  = STALL_MEM_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        err_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i
);

  state_t           state;
  logic [REG_W-1:0] rd_buf;
  logic             expire;
  logic             busy;
  logic             request;
  logic             mem_stalled;
  logic             unused_stall;

  assign busy        = (state == BUSY);
  assign request     = (cpu_ce_i == CHIP_ENABLE) && !flush_i;
  assign mem_stalled = stall_i[STALL_MEM_BIT];
  // The other stall bits belong to other stages; only MEM matters here.
  assign unused_stall = ^stall_i;

  // Counter runs only while a transaction is open and restarts from zero for
  // every new one because it is held clear in all other states.
  bus_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy),
    .expire (expire)
  );

  // Stall and read data are combinational so MEM is stalled in the very cycle
  // it raises the request, and released in the very cycle the bus answers.
  always_comb begin
    // NOTE: every output gets a default first; without it a missed branch
    // would infer a latch.
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;
    if (!rst) begin
      unique case (state)
        IDLE: stallreq_o = request;
        BUSY: begin
          // Flush outranks ack and timeout: the access is abandoned silently.
          if (!flush_i) begin
            if (bus_ack_i) begin
              if (bus_we_o != WRITE_ENABLE) cpu_data_o = bus_data_i;
            end else begin
              stallreq_o = !expire;
            end
          end
        end
        WAIT_RELEASE: cpu_data_o = rd_buf;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_buf     <= ZERO_WORD;
      err_o      <= 1'b0;
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= 4'b0000;
      bus_addr_o <= ZERO_WORD;
      bus_data_o <= ZERO_WORD;
    end else begin
      err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (request) begin
            bus_cyc_o  <= 1'b1;
            bus_stb_o  <= 1'b1;
            bus_we_o   <= cpu_we_i;
            bus_sel_o  <= cpu_sel_i;
            bus_addr_o <= cpu_addr_i;
            bus_data_o <= cpu_data_i;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= 4'b0000;
            rd_buf    <= ZERO_WORD;
            state     <= IDLE;
          end else if (bus_ack_i || expire) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= 4'b0000;
            // Ack wins over a timeout landing in the same cycle.
            rd_buf    <= (bus_ack_i && (bus_we_o != WRITE_ENABLE)) ? bus_data_i : ZERO_WORD;
            err_o     <= !bus_ack_i;
            // If MEM is still frozen, park the read data until it is released.
            state     <= mem_stalled ? WAIT_RELEASE : IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (!mem_stalled || flush_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_if.sv
// tb_data_bus_if: directed scoreboard bench for data_bus_if (TIMEOUT_CYCLES=4).
// The stimulus process drives one cycle at a time and queues the outputs it
// expects for that cycle; the monitor pops and compares on each falling edge.
module tb_data_bus_if;

  typedef struct {
    logic        stallreq;
    logic [31:0] cpu_data;
    logic        err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic [5:0]  stall;
  logic        flush;
  logic        err;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  data_bus_if #(.TIMEOUT_CYCLES(4), .CNT_W(8), .STALL_MEM_BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce),
    .cpu_we_i   (cpu_we),
    .cpu_sel_i  (cpu_sel),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_rdata),
    .stallreq_o (stallreq),
    .stall_i    (stall),
    .flush_i    (flush),
    .err_o      (err),
    .bus_cyc_o  (bus_cyc),
    .bus_stb_o  (bus_stb),
    .bus_we_o   (bus_we),
    .bus_sel_o  (bus_sel),
    .bus_addr_o (bus_addr),
    .bus_data_o (bus_wdata),
    .bus_data_i (bus_rdata),
    .bus_ack_i  (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic sr, input logic [31:0] cd, input logic er,
                              input logic cs, input logic w, input logic [3:0] sl,
                              input logic [31:0] ad, input logic [31:0] dt);
    exp_t e;
    e.stallreq = sr;
    e.cpu_data = cd;
    e.err      = er;
    e.cyc      = cs;
    e.stb      = cs;
    e.we       = w;
    e.sel      = sl;
    e.addr     = ad;
    e.data     = dt;
    return e;
  endfunction

  task automatic push(input exp_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Inputs change 1 time unit after the rising edge, well away from sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one queued expectation per cycle, compared on the falling edge.
  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".stallreq"}, 32'(stallreq),  32'(e.stallreq));
        check({t, ".cpu_data"}, cpu_rdata,      e.cpu_data);
        check({t, ".err"},      32'(err),       32'(e.err));
        check({t, ".cyc"},      32'(bus_cyc),   32'(e.cyc));
        check({t, ".stb"},      32'(bus_stb),   32'(e.stb));
        check({t, ".we"},       32'(bus_we),    32'(e.we));
        check({t, ".sel"},      32'(bus_sel),   32'(e.sel));
        check({t, ".addr"},     bus_addr,       e.addr);
        check({t, ".data"},     bus_wdata,      e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t zero;
    zero = ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    // NOTE: bench drives use blocking assignments; the #1 offset after the
    // edge keeps them clear of the DUT's sampling.
    rst = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_sel = 4'h0; cpu_addr = 32'h0;
    cpu_wdata = 32'h0; stall = 6'h00; flush = 1'b0; bus_rdata = 32'h0; bus_ack = 1'b0;

    // Reset: registers cleared, stall suppressed even with a request present.
    tick(); push(zero, "rst0");
    tick(); cpu_ce = 1'b1; cpu_addr = 32'h10; push(zero, "rst_ce");
    tick(); rst = 1'b0; cpu_ce = 1'b0; cpu_addr = 32'h0; push(zero, "post_rst");

    // 1: read, ack in first BUSY cycle.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0), "t1_req");
    tick(); bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    push(ex(0, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h10, 32'h0), "t1_ack");
    tick(); cpu_ce = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h10, 32'h0), "t1_idle");

    // 2: write, 3 wait states; ack coincides with the timeout limit and wins.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b1; cpu_sel = 4'h3; cpu_addr = 32'h20; cpu_wdata = 32'h12341234;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h10, 32'h0), "t2_req");
    for (int i = 0; i < 3; i++) begin
      tick(); push(ex(1, 32'h0, 0, 1, 1, 4'h3, 32'h20, 32'h12341234), "t2_wait");
    end
    tick(); bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    push(ex(0, 32'h0, 0, 1, 1, 4'h3, 32'h20, 32'h12341234), "t2_ack");
    tick(); cpu_ce = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h20, 32'h12341234), "t2_idle");

    // 3: read acked while MEM is stalled; data held through WAIT_RELEASE.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h30; cpu_wdata = 32'h0;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h20, 32'h12341234), "t3_req");
    tick(); bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5; stall = 6'b011111;
    push(ex(0, 32'hA5A5A5A5, 0, 1, 0, 4'hF, 32'h30, 32'h0), "t3_ack");
    tick(); bus_ack = 1'b0; bus_rdata = 32'h0;
    push(ex(0, 32'hA5A5A5A5, 0, 0, 0, 4'h0, 32'h30, 32'h0), "t3_hold0");
    tick(); bus_ack = 1'b1; bus_rdata = 32'h11111111;
    push(ex(0, 32'hA5A5A5A5, 0, 0, 0, 4'h0, 32'h30, 32'h0), "t3_hold1");
    tick(); bus_ack = 1'b0; bus_rdata = 32'h0;
    push(ex(0, 32'hA5A5A5A5, 0, 0, 0, 4'h0, 32'h30, 32'h0), "t3_hold2");
    tick(); stall = 6'h00; cpu_ce = 1'b0;
    push(ex(0, 32'hA5A5A5A5, 0, 0, 0, 4'h0, 32'h30, 32'h0), "t3_release");
    tick(); push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h30, 32'h0), "t3_idle");

    // 4: flush with ack in the 2nd BUSY cycle; then flush blocks an IDLE request.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h40;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h30, 32'h0), "t4_req");
    tick(); push(ex(1, 32'h0, 0, 1, 0, 4'hF, 32'h40, 32'h0), "t4_busy");
    tick(); bus_ack = 1'b1; flush = 1'b1; bus_rdata = 32'h99999999;
    push(ex(0, 32'h0, 0, 1, 0, 4'hF, 32'h40, 32'h0), "t4_flush");
    tick(); cpu_ce = 1'b0; bus_ack = 1'b0; flush = 1'b0; bus_rdata = 32'h0;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h40, 32'h0), "t4_idle");
    tick(); cpu_ce = 1'b1; flush = 1'b1; cpu_addr = 32'h44;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h40, 32'h0), "t4_flush_idle");
    tick(); cpu_ce = 1'b0; flush = 1'b0;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h40, 32'h0), "t4_no_txn");

    // 5: timeout after 4 BUSY cycles; late ack ignored.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h50;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h40, 32'h0), "t5_req");
    for (int i = 0; i < 3; i++) begin
      tick(); push(ex(1, 32'h0, 0, 1, 0, 4'hF, 32'h50, 32'h0), "t5_wait");
    end
    tick(); push(ex(0, 32'h0, 0, 1, 0, 4'hF, 32'h50, 32'h0), "t5_expire");
    tick(); cpu_ce = 1'b0;
    push(ex(0, 32'h0, 1, 0, 0, 4'h0, 32'h50, 32'h0), "t5_err");
    tick(); bus_ack = 1'b1; bus_rdata = 32'h77777777;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h50, 32'h0), "t5_late_ack");
    tick(); bus_ack = 1'b0; bus_rdata = 32'h0;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h50, 32'h0), "t5_idle");

    // 6: reset in the middle of a write.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF; cpu_addr = 32'h60; cpu_wdata = 32'hCAFEF00D;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h50, 32'h0), "t6_req");
    tick(); push(ex(1, 32'h0, 0, 1, 1, 4'hF, 32'h60, 32'hCAFEF00D), "t6_busy");
    tick(); rst = 1'b1;
    push(ex(0, 32'h0, 0, 1, 1, 4'hF, 32'h60, 32'hCAFEF00D), "t6_rst");
    tick(); rst = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_sel = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    push(zero, "t6_post_rst");

    // Request after reset, then a back-to-back write one cycle after the ack.
    tick(); cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'h8; cpu_addr = 32'h70;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0), "t7_req");
    tick(); bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    push(ex(0, 32'h0BADF00D, 0, 1, 0, 4'h8, 32'h70, 32'h0), "t7_ack");
    tick(); bus_ack = 1'b0; bus_rdata = 32'h0; cpu_we = 1'b1; cpu_sel = 4'h1; cpu_addr = 32'h74; cpu_wdata = 32'h000000AB;
    push(ex(1, 32'h0, 0, 0, 0, 4'h0, 32'h70, 32'h0), "t7_b2b_req");
    tick(); bus_ack = 1'b1;
    push(ex(0, 32'h0, 0, 1, 1, 4'h1, 32'h74, 32'h000000AB), "t7_b2b_ack");
    tick(); cpu_ce = 1'b0; bus_ack = 1'b0;
    push(ex(0, 32'h0, 0, 0, 0, 4'h0, 32'h74, 32'h000000AB), "t7_idle");

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
